// File: rtl/nes_joypad_port_pkg.sv
// Shared constants for the NES joypad port: button bit positions, shift-count width and saturation.
// Also holds the opposite-direction filter used by each port.
package nes_joypad_port_pkg;

    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

    localparam int               CNT_W   = 4;
    localparam logic [CNT_W-1:0] CNT_SAT = 4'd8;

    // A real d-pad cannot press both opposites; some games crash if they see it.
    function automatic logic [7:0] filter_opposite(input logic [7:0] btn);
        logic [7:0] f;
        f = btn;
        if (btn[BTN_LEFT] && btn[BTN_RIGHT]) begin
            f[BTN_LEFT]  = 1'b0;
            f[BTN_RIGHT] = 1'b0;
        end
        if (btn[BTN_UP] && btn[BTN_DOWN]) begin
            f[BTN_UP]   = 1'b0;
            f[BTN_DOWN] = 1'b0;
        end
        return f;
    endfunction

endpackage

// File: rtl/nes_joypad_shreg.sv
// One controller port: 4021-style parallel-load shift register with read-end shifting,
// saturating shift count and registered serial/done outputs.
module nes_joypad_shreg
    import nes_joypad_port_pkg::*;
#(
    parameter bit c_block_opposite = 1'b1
) (
    input  logic       i_clk,
    input  logic       i_rstn,
    input  logic [7:0] i_btn,
    input  logic       i_strobe,
    input  logic       i_rd,
    output logic       o_data,
    output logic       o_done
);

    logic [7:0]       shreg_q, shreg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rd_q, rd_d;
    logic             data_q, data_d;
    logic             done_q, done_d;
    logic [7:0]       btn_filt;
    logic             read_end;

    always_comb begin
        btn_filt = c_block_opposite ? filter_opposite(i_btn) : i_btn;
        read_end = rd_q && !i_rd;
        rd_d     = i_rd;
        shreg_d  = shreg_q;
        cnt_d    = cnt_q;
        if (i_strobe) begin
            shreg_d = btn_filt;
            cnt_d   = '0;
        end else if (read_end) begin
            // Ones fill from the top so an over-read port reports "pressed", like the real pad.
            shreg_d = {1'b1, shreg_q[7:1]};
            cnt_d   = (cnt_q == CNT_SAT) ? CNT_SAT : cnt_q + CNT_W'(1);
        end
        data_d = shreg_q[0];
        done_d = (cnt_q == CNT_SAT);
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            shreg_q <= '0;
            cnt_q   <= '0;
            rd_q    <= 1'b0;
            data_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

    assign o_data = data_q;
    assign o_done = done_q;

endmodule

// File: rtl/nes_joypad_port.sv
// Two-port NES controller interface fed from decoded USB button state.
// The strobe is shared; each port has its own read enable and shift register.
module nes_joypad_port
    import nes_joypad_port_pkg::*;
#(
    parameter bit c_block_opposite = 1'b1
) (
    input  logic       i_clk,
    input  logic       i_rstn,
    input  logic [7:0] i_btn0,
    input  logic [7:0] i_btn1,
    input  logic       i_strobe,
    input  logic [1:0] i_rd,
    output logic [1:0] o_data,
    output logic [1:0] o_done
);

    nes_joypad_shreg #(.c_block_opposite(c_block_opposite)) u_port0 (
        .i_clk    (i_clk),
        .i_rstn   (i_rstn),
        .i_btn    (i_btn0),
        .i_strobe (i_strobe),
        .i_rd     (i_rd[0]),
        .o_data   (o_data[0]),
        .o_done   (o_done[0])
    );

    nes_joypad_shreg #(.c_block_opposite(c_block_opposite)) u_port1 (
        .i_clk    (i_clk),
        .i_rstn   (i_rstn),
        .i_btn    (i_btn1),
        .i_strobe (i_strobe),
        .i_rd     (i_rd[1]),
        .o_data   (o_data[1]),
        .o_done   (o_done[1])
    );

endmodule

// File: tb/tb_nes_joypad_port.sv
// Directed bench for nes_joypad_port: filtered and unfiltered instances share all inputs.
module tb_nes_joypad_port;

    logic       i_clk = 1'b0;
    logic       i_rstn;
    logic [7:0] i_btn0, i_btn1;
    logic       i_strobe;
    logic [1:0] i_rd;
    logic [1:0] o_data, o_done;
    logic [1:0] o_data_nb, o_done_nb;

    int total = 0;
    int bad   = 0;

    always #5 i_clk = ~i_clk;

    nes_joypad_port #(.c_block_opposite(1'b1)) dut (
        .i_clk(i_clk), .i_rstn(i_rstn), .i_btn0(i_btn0), .i_btn1(i_btn1),
        .i_strobe(i_strobe), .i_rd(i_rd), .o_data(o_data), .o_done(o_done)
    );

    nes_joypad_port #(.c_block_opposite(1'b0)) dut_nb (
        .i_clk(i_clk), .i_rstn(i_rstn), .i_btn0(i_btn0), .i_btn1(i_btn1),
        .i_strobe(i_strobe), .i_rd(i_rd), .o_data(o_data_nb), .o_done(o_done_nb)
    );

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_strobe(input logic [7:0] b0, input logic [7:0] b1);
        i_btn0   = b0;
        i_btn1   = b1;
        i_rd     = 2'b00;
        i_strobe = 1'b1;
        tick();
        i_strobe = 1'b0;
        tick();
        tick();
    endtask

    // n reads on the ports in m; read i sees bit i of the expected byte, 1 once exhausted.
    task automatic seq(input string tag, input logic [1:0] m, input logic [7:0] e0,
                       input logic [7:0] e1, input logic [7:0] enb, input int n);
        for (int i = 0; i < n; i++) begin
            i_rd = m;
            tick();
            if (m[0]) begin
                chk($sformatf("%s_d0[%0d]", tag, i), {7'd0, o_data[0]}, {7'd0, (i < 8) ? e0[i] : 1'b1});
                chk($sformatf("%s_nb[%0d]", tag, i), {7'd0, o_data_nb[0]}, {7'd0, (i < 8) ? enb[i] : 1'b1});
            end
            if (m[1])
                chk($sformatf("%s_d1[%0d]", tag, i), {7'd0, o_data[1]}, {7'd0, (i < 8) ? e1[i] : 1'b1});
            i_rd = 2'b00;
            tick();
            tick();
            if (m[0])
                chk($sformatf("%s_done0[%0d]", tag, i), {7'd0, o_done[0]}, {7'd0, (i >= 7)});
            if (m[1])
                chk($sformatf("%s_done1[%0d]", tag, i), {7'd0, o_done[1]}, {7'd0, (i >= 7)});
        end
    endtask

    initial begin
        i_rstn   = 1'b0;
        i_btn0   = 8'h00;
        i_btn1   = 8'h00;
        i_strobe = 1'b0;
        i_rd     = 2'b00;
        tick();
        tick();
        chk("rst_data", {6'd0, o_data}, 8'h00);
        chk("rst_done", {6'd0, o_done}, 8'h00);
        i_rstn = 1'b1;
        tick();

        // A only
        do_strobe(8'h01, 8'h00);
        chk("a_done_after_strobe", {6'd0, o_done}, 8'h00);
        seq("a_only", 2'b01, 8'h01, 8'h00, 8'h01, 8);

        // Left+Right masked only in the filtering instance; then Up+Down
        do_strobe(8'hC0, 8'h00);
        seq("lr", 2'b01, 8'h00, 8'h00, 8'hC0, 8);
        do_strobe(8'h30, 8'h00);
        seq("ud", 2'b01, 8'h00, 8'h00, 8'h30, 8);

        // Over-reading keeps returning 1 and done stays set; then a fresh load clears done
        do_strobe(8'h02, 8'h00);
        seq("over", 2'b01, 8'h02, 8'h00, 8'h02, 12);
        do_strobe(8'h00, 8'h00);
        chk("reload_done", {7'd0, o_done[0]}, 8'h00);
        chk("reload_data0", {7'd0, o_data[0]}, 8'h00);
        do_strobe(8'h01, 8'h00);
        chk("reload_data1", {7'd0, o_data[0]}, 8'h01);

        // Strobe held: register follows buttons, reads ignored
        i_strobe = 1'b1;
        i_btn0   = 8'h00;
        tick();
        tick();
        chk("hold_a0", {7'd0, o_data[0]}, 8'h00);
        i_btn0 = 8'h01;
        i_rd   = 2'b01;
        tick();
        chk("hold_lag", {7'd0, o_data[0]}, 8'h00);
        i_rd = 2'b00;
        tick();
        chk("hold_a1", {7'd0, o_data[0]}, 8'h01);
        i_btn0 = 8'h00;
        i_rd   = 2'b01;
        tick();
        chk("hold_lag2", {7'd0, o_data[0]}, 8'h01);
        i_rd = 2'b00;
        tick();
        chk("hold_a0b", {7'd0, o_data[0]}, 8'h00);
        chk("hold_done", {7'd0, o_done[0]}, 8'h00);
        i_btn0 = 8'h01;
        tick();
        i_strobe = 1'b0;
        tick();
        // Button changes after strobe falls must not reach the register
        i_btn0 = 8'hFE;
        tick();
        seq("frozen", 2'b01, 8'h01, 8'h00, 8'h01, 8);

        // Both ports read in the same cycles
        do_strobe(8'h5A, 8'hA5);
        seq("dual", 2'b11, 8'h5A, 8'hA5, 8'h5A, 8);

        // Reset mid-sequence, then shift out of the cleared register
        do_strobe(8'h0F, 8'h00);
        seq("pre_rst", 2'b01, 8'h0F, 8'h00, 8'h0F, 3);
        chk("pre_rst_data", {7'd0, o_data[0]}, 8'h01);
        i_rstn = 1'b0;
        #1;
        chk("mid_rst_data", {6'd0, o_data}, 8'h00);
        chk("mid_rst_done", {6'd0, o_done}, 8'h00);
        chk("mid_rst_nb", {6'd0, o_data_nb}, 8'h00);
        tick();
        i_rstn = 1'b1;
        tick();
        seq("post_rst", 2'b01, 8'h00, 8'h00, 8'h00, 9);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nes_joypad_port.md
NES_JOYPAD_PORT -- requirements
Module: nes_joypad_port

Interface
REQ-001 Parameter c_block_opposite, default 1: when 1, mask physically impossible direction pairs before loading.
REQ-002 Port i_clk, input, 1: single clock, same domain as the USB report decoder and the NES CPU bus strobes.
REQ-003 Port i_rstn, input, 1: reset, asynchronous and active-low.
REQ-004 Port i_btn0, input, 8: player-1 button state; bit 0..7 = A, B, Select, Start, Up, Down, Left, Right (1 = pressed).
REQ-005 Port i_btn1, input, 8: player-2 button state, same bit order.
REQ-006 Port i_strobe, input, 1: level of the CPU $4016 write bit 0, common to both ports.
REQ-007 Port i_rd, input, 2: CPU read-enable level; bit p is active while the CPU reads the port-p register ($4016 or $4017).
REQ-008 Port o_data, output, 2: serial button bit per port, registered, 1 = pressed.
REQ-009 Port o_done, output, 2: per port, 1 when 8 or more shifts have occurred since the last reload.

Function
REQ-010 The block SHALL derive a filtered byte per port; with c_block_opposite=1, Left+Right both set clears both bits, and Up+Down both set clears both bits; other bits pass unchanged.
REQ-011 While i_strobe=1, each cycle the block SHALL load the filtered byte into the 8-bit shift register of each port and clear its shift count to 0.
REQ-012 The block SHALL register i_rd per port and detect a read end as previous=1, current=0 (falling edge); shifting on read end matches 4021 timing.
REQ-013 On a read end with i_strobe=0, the block SHALL shift the register right by one, insert 1 at bit 7, and increment the 4-bit count, saturating at 8.
REQ-014 A read end coinciding with i_strobe=1 SHALL be ignored; reload wins.
REQ-015 The i_strobe falling edge SHALL freeze the last reloaded value; no extra load occurs.
REQ-016 The block SHALL set o_data[p] to bit 0 of the port-p shift register, registered, so a change is visible 1 cycle after the register update (2 cycles after the i_rd falling edge).
REQ-017 After 8 shifts, o_data[p] SHALL read 1 indefinitely (official-controller behaviour) until the next reload.
REQ-018 o_done[p] SHALL be registered and equal (count==8).
REQ-019 Ports SHALL operate independently; simultaneous read ends on both ports in one cycle SHALL both shift.
REQ-020 i_btn changes while i_strobe=0 SHALL NOT affect the shift registers.

Reset
REQ-021 Asserting i_rstn=0 SHALL asynchronously clear to 0: both shift registers, counts, registered i_rd, o_data and o_done.
REQ-022 Reset asserted mid-sequence SHALL abandon the sequence; after release, the first read end with no intervening strobe SHALL shift in 1s from the cleared register (o_data=0 for 8 reads, then 1).
REQ-023 Reset deassertion need not be synchronised inside the block; the top level provides a synchronised release.

Structure
REQ-024 The shared package SHALL hold button bit-index constants (A=0 .. Right=7), the count width (4), and the saturation value (8).
REQ-025 One sub-module, nes_joypad_shreg (filter, edge detect, shift register, count, output registers), SHALL be instantiated twice; the top SHALL distribute i_strobe and split the vectors.

Verification
REQ-026 i_btn0=8'h01, pulse i_strobe, then 8 reads on port 0 -> o_data[0] sequence 1,0,0,0,0,0,0,0; o_done[0]=1 after the 8th.
REQ-027 i_btn0=8'hC0 (Left+Right), c_block_opposite=1, strobe, 8 reads -> all 0; with c_block_opposite=0 -> 0,0,0,0,0,0,1,1.
REQ-028 After 8 reads, 4 more reads -> o_data[0]=1 each, count stays 8; a new strobe -> o_done[0]=0, o_data[0]=new A.
REQ-029 i_strobe held 1 with i_btn0 toggling 8'h00/8'h01 and reads issued -> o_data[0] tracks A with 1-cycle lag, count stays 0.
REQ-030 i_btn0=8'h5A, i_btn1=8'hA5, strobe, i_rd=2'b11 reads in the same cycles -> port 0 gives 0,1,0,1,1,0,1,0; port 1 gives 1,0,1,0,0,1,0,1.
REQ-031 Assert i_rstn=0 after 3 reads -> o_data=0, o_done=0 immediately; release, 9 reads without strobe -> 0 x8, then 1.
